// File: rtl/graph_plotter.sv
// Snapshots a frame of Q16.16 graph points and streams visible ones to the framebuffer as pixel writes.
// Define GRAPH_PLOTTER_CLEAR_EN to clear the whole screen (wr_color=0) before plotting.
module graph_plotter #(
  parameter int N_POINTS = 64,
  parameter int FRAC     = 16,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int X_ORG    = 320,
  parameter int Y_ORG    = 240,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int IW       = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  complete,
  input  logic [32*N_POINTS-1:0] xs_flat,
  input  logic [32*N_POINTS-1:0] ys_flat,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [XW-1:0]         wr_x,
  output logic [YW-1:0]         wr_y,
  output logic                  wr_color,
  output logic                  busy,
  output logic                  done,
  output logic [IW:0]           clipped
);

  localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef GRAPH_PLOTTER_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
`endif
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [IW-1:0]      LAST_IDX = IW'(N_POINTS - 1);
  localparam logic signed [32:0] X_ORG_S  = 33'(X_ORG);
  localparam logic signed [32:0] Y_ORG_S  = 33'(Y_ORG);
  localparam logic signed [32:0] H_LIM    = 33'(H_RES);
  localparam logic signed [32:0] V_LIM    = 33'(V_RES);

  // Integer part of Q16.16, widened so the origin offset cannot wrap before clipping.
  function automatic logic signed [32:0] map_x(input logic signed [31:0] v);
    logic signed [31:0] s;
    logic signed [32:0] e;
    s = v >>> FRAC;
    e = {s[31], s};
    return X_ORG_S + e;
  endfunction

  function automatic logic signed [32:0] map_y(input logic signed [31:0] v);
    logic signed [31:0] s;
    logic signed [32:0] e;
    s = v >>> FRAC;
    e = {s[31], s};
    return Y_ORG_S - e;
  endfunction

  function automatic logic on_screen(input logic signed [32:0] px,
                                     input logic signed [32:0] py);
    return (px >= 33'sd0) && (px < H_LIM) && (py >= 33'sd0) && (py < V_LIM);
  endfunction

  logic [2:0]              state;
  logic [IW-1:0]           idx;
  logic                    complete_d;
  logic [32*N_POINTS-1:0]  xs_snap;
  logic [32*N_POINTS-1:0]  ys_snap;
  logic signed [31:0]      x_cur;
  logic signed [31:0]      y_cur;
  logic signed [32:0]      px;
  logic signed [32:0]      py;
  logic                    vis;
  logic                    start;

  assign start = complete && !complete_d;
  assign x_cur = xs_snap[32*idx +: 32];
  assign y_cur = ys_snap[32*idx +: 32];
  assign px    = map_x(x_cur);
  assign py    = map_y(y_cur);
  assign vis   = on_screen(px, py);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      complete_d <= 1'b0;
      xs_snap    <= '0;
      ys_snap    <= '0;
      wr_valid   <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_color   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clipped    <= '0;
    end else begin
      complete_d <= complete;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            xs_snap <= xs_flat;
            ys_snap <= ys_flat;
            clipped <= '0;
            idx     <= '0;
            busy    <= 1'b1;
`ifdef GRAPH_PLOTTER_CLEAR_EN
            state    <= S_CLEAR;
            wr_valid <= 1'b1;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_color <= 1'b0;
`else
            state    <= S_CALC;
`endif
          end
        end
`ifdef GRAPH_PLOTTER_CLEAR_EN
        // Clear walk uses wr_x/wr_y directly as the raster counter, x fastest.
        S_CLEAR: begin
          if (wr_ready) begin
            if (wr_x == X_LAST && wr_y == Y_LAST) begin
              wr_valid <= 1'b0;
              state    <= S_CALC;
            end else if (wr_x == X_LAST) begin
              wr_x <= '0;
              wr_y <= wr_y + 1'b1;
            end else begin
              wr_x <= wr_x + 1'b1;
            end
          end
        end
`endif
        S_CALC: begin
          if (vis) begin
            wr_x     <= px[XW-1:0];
            wr_y     <= py[YW-1:0];
            wr_color <= 1'b1;
            wr_valid <= 1'b1;
            state    <= S_WRITE;
          end else begin
            clipped <= clipped + 1'b1;
            if (idx == LAST_IDX) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_CALC;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_graph_plotter.sv
// Directed bench for graph_plotter: scoreboard of expected pixel writes checked at each handshake.
module tb_graph_plotter;
  localparam int N = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           complete = 1'b0;
  logic           wr_ready = 1'b0;
  logic [32*N-1:0] xs = '0;
  logic [32*N-1:0] ys = '0;
  logic           wr_valid, wr_color, busy, done;
  logic [9:0]     wr_x;
  logic [8:0]     wr_y;
  logic [6:0]     clipped;

  always #5 clk = ~clk;

  graph_plotter dut (
    .clk(clk), .rst(rst), .complete(complete), .xs_flat(xs), .ys_flat(ys),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .busy(busy), .done(done), .clipped(clipped)
  );

  int n_tests = 0, n_fail = 0, n_writes = 0;
  int stall = 0, wait_cnt = 0;
  bit pending = 0;
  int exp_clip = 0, exp_vis = 0;
  logic [18:0] q[$];
  logic [18:0] e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference mapping: integer part via arithmetic shift, then origin offset and range test.
  task automatic load_model();
    exp_clip = 0;
    exp_vis  = 0;
    for (int i = 0; i < N; i++) begin
      int xv, yv, px, py;
      xv = xs[32*i +: 32];
      yv = ys[32*i +: 32];
      px = 320 + (xv >>> 16);
      py = 240 - (yv >>> 16);
      if (px >= 0 && px < 640 && py >= 0 && py < 480) begin
        q.push_back({px[9:0], py[8:0]});
        exp_vis++;
      end else begin
        exp_clip++;
      end
    end
  endtask

  // Framebuffer side: applies the stall policy and scores every write.
  always @(negedge clk) begin
    if (rst) begin
      wait_cnt = 0;
      pending  = 0;
      wr_ready = 1'b0;
    end else begin
      wr_ready = (wait_cnt >= stall);
      if (pending) check("valid_hold", {63'd0, wr_valid}, 64'd1);
      if (wr_valid) begin
        if (q.size() == 0) begin
          check("unexpected_write", {63'd0, wr_valid}, 64'd0);
          wait_cnt = 0;
          pending  = 0;
        end else if (wr_ready) begin
          e = q.pop_front();
          check("wr_x", {54'd0, wr_x}, {54'd0, e[18:9]});
          check("wr_y", {55'd0, wr_y}, {55'd0, e[8:0]});
          check("wr_color", {63'd0, wr_color}, 64'd1);
          n_writes++;
          wait_cnt = 0;
          pending  = 0;
        end else begin
          check("stall_xy", {45'd0, wr_x, wr_y}, {45'd0, q[0]});
          wait_cnt++;
          pending = 1;
        end
      end
    end
  end

  task automatic run_frame(input int budget, input int glitch, input int chg,
                           output int first_v, output int done_at);
    int cyc, done_cnt, w0;
    cyc = 0;
    done_cnt = 0;
    first_v = -1;
    done_at = -1;
    w0 = n_writes;
    load_model();
    @(negedge clk);
    complete = 1'b1;
    while (cyc < budget && (done_at < 0 || cyc <= done_at)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_start", {63'd0, busy}, 64'd1);
      if (cyc == glitch - 2) complete = 1'b0;
      if (cyc == glitch) complete = 1'b1;
      if (cyc == chg) begin
        xs = {N{32'(400 << 16)}};
        ys = xs;
      end
      if (wr_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = cyc;
          check("busy_at_done", {63'd0, busy}, 64'd0);
        end
      end
    end
    check("done_seen", {63'd0, done_at >= 0}, 64'd1);
    check("done_width", 64'(done_cnt), 64'd1);
    check("busy_after", {63'd0, busy}, 64'd0);
    check("clipped", {57'd0, clipped}, 64'(exp_clip));
    check("frame_writes", 64'(n_writes - w0), 64'(exp_vis));
    check("queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int hi, w0;
    hi = 0;
    w0 = n_writes;
    repeat (cycles) begin
      @(negedge clk);
      if (busy || done || wr_valid) hi++;
    end
    check(tag, 64'(hi + n_writes - w0), 64'd0);
  endtask

  task automatic ramp();
    for (int i = 0; i < N; i++) begin
      xs[32*i +: 32] = i << 16;
      ys[32*i +: 32] = -(i << 16);
    end
  endtask

  initial begin
    int fv, da;
    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, wr_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {40'd0, wr_valid, wr_color, busy, done, clipped, wr_x, wr_y}, 64'd0);
    quiet(100, "idle_quiet");

    // All points at the origin, then complete held high
    xs = '0;
    ys = '0;
    run_frame(300, 0, 0, fv, da);
    check("latency", 64'(fv), 64'd2);
    check("origin_done_at", 64'(da), 64'd129);
    quiet(30, "held_no_restart");
    complete = 1'b0;
    @(negedge clk);

    // Diagonal ramp, one write per two cycles
    ramp();
    run_frame(300, 0, 0, fv, da);
    check("ramp_done_at", 64'(da), 64'd129);
    complete = 1'b0;

    // Two off-screen points
    xs = '0;
    ys = '0;
    xs[32*5 +: 32] = 400 << 16;
    ys[32*9 +: 32] = -(300 << 16);
    run_frame(300, 0, 0, fv, da);
    check("clip2_clipped", {57'd0, clipped}, 64'd2);
    check("clip2_done_at", 64'(da), 64'd127);
    complete = 1'b0;

    // Screen edges, fractions and extremes
    xs = '0;
    ys = '0;
    xs[32*0 +: 32] = 319 << 16;
    xs[32*1 +: 32] = 320 << 16;
    xs[32*2 +: 32] = -(320 << 16);
    xs[32*3 +: 32] = -(321 << 16);
    ys[32*4 +: 32] = 240 << 16;
    ys[32*5 +: 32] = 241 << 16;
    ys[32*6 +: 32] = -(239 << 16);
    ys[32*7 +: 32] = -(240 << 16);
    xs[32*8 +: 32] = 32'hFFFF_FFFF;
    ys[32*9 +: 32] = 32'h0000_FFFF;
    xs[32*10 +: 32] = 32'h7FFF_0000;
    xs[32*11 +: 32] = 32'h8000_0000;
    ys[32*12 +: 32] = 32'h8000_0000;
    run_frame(300, 0, 0, fv, da);
    check("edge_clipped", {57'd0, clipped}, 64'd7);
    complete = 1'b0;

    // Random points with a slow framebuffer
    for (int i = 0; i < N; i++) begin
      int vx, vy;
      vx = int'($urandom_range(0, 900)) - 450;
      vy = int'($urandom_range(0, 640)) - 320;
      xs[32*i +: 32] = (vx << 16) | int'($urandom_range(0, 65535));
      ys[32*i +: 32] = (vy << 16) | int'($urandom_range(0, 65535));
    end
    stall = 7;
    run_frame(1200, 0, 0, fv, da);
    stall = 0;
    complete = 1'b0;

    // Re-trigger mid-frame is ignored; inputs changed mid-frame are not seen
    ramp();
    run_frame(300, 10, 5, fv, da);
    check("retrig_done_at", 64'(da), 64'd129);
    quiet(50, "retrig_no_restart");
    complete = 1'b0;

    // Reset mid-frame aborts without done
    ramp();
    stall = 3;
    load_model();
    @(negedge clk);
    complete = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    complete = 1'b0;
    #1;
    check("abort_valid", {63'd0, wr_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_clipped", {57'd0, clipped}, 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stall = 0;
    quiet(30, "abort_no_done");

    // Recovery frame
    ramp();
    run_frame(300, 0, 0, fv, da);
    check("recover_done_at", 64'(da), 64'd129);
    complete = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
